// File: rtl/timer_reader.sv
// Requester for a t_en/t_valid/t_out value generator: captures each served sample
// into a show-ahead FIFO read by a downstream stage, with a request timeout.
module timer_reader #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  output logic                       t_en_o,
  input  logic                       t_valid_i,
  input  logic [15:0]                t_out_i,
  input  logic                       rd_en_i,
  output logic [15:0]                data_out_o,
  output logic                       data_valid_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       timeout_err_o,
  output logic                       drop_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_REQ  = 1'b1;

  logic          state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  logic          drop_q, drop_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          full, wr, rd;

  assign full = (count_q == CW'(DEPTH));
  // Requests are only launched when not full, so a capture never needs a full check.
  assign rd   = rd_en_i && (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    drop_d  = 1'b0;
    wr      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (full) begin
            drop_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        // A sample arriving on the final cycle beats the timeout.
        if (t_valid_i) begin
          wr      = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      drop_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      if (wr) begin
        mem_q[wr_ptr_q] <= t_out_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr, rd})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign t_en_o        = (state_q == ST_REQ);
  assign data_valid_o  = (count_q != '0);
  assign data_out_o    = data_valid_o ? mem_q[rd_ptr_q] : 16'h0000;
  assign full_o        = full;
  assign count_o       = count_q;
  assign timeout_err_o = tmo_q;
  assign drop_err_o    = drop_q;

endmodule

// File: tb/tb_timer_reader.sv
// Bench for timer_reader: directed scenarios plus random traffic, all scored
// against a queue-based model of the requester and FIFO.
module tb_timer_reader;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i, t_valid_i, rd_en_i;
  logic [15:0]   t_out_i;
  logic          t_en_o, data_valid_o, full_o, timeout_err_o, drop_err_o;
  logic [15:0]   data_out_o;
  logic [CW-1:0] count_o;

  timer_reader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .t_en_o(t_en_o),
    .t_valid_i(t_valid_i), .t_out_i(t_out_i), .rd_en_i(rd_en_i),
    .data_out_o(data_out_o), .data_valid_o(data_valid_o), .full_o(full_o),
    .count_o(count_o), .timeout_err_o(timeout_err_o), .drop_err_o(drop_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: request in flight + cycles spent in it, and a FIFO queue.
  bit          m_busy;
  int          m_age;
  logic [15:0] m_q[$];
  bit          m_tmo, m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_q.delete(); m_tmo = 0; m_drop = 0;
  endtask

  task automatic model_edge(input bit st, input bit tv, input logic [15:0] tout, input bit rd);
    int pre_size = m_q.size();
    m_tmo  = 0;
    m_drop = 0;
    if (rd && pre_size > 0) m_q.delete(0);
    if (m_busy) begin
      if (tv) begin
        m_q.push_back(tout);
        m_busy = 0;
      end else if (m_age == TIMEOUT - 1) begin
        m_tmo  = 1;
        m_busy = 0;
      end else begin
        m_age++;
      end
    end else if (st) begin
      if (pre_size == DEPTH) m_drop = 1;
      else begin
        m_busy = 1;
        m_age  = 0;
      end
    end
  endtask

  task automatic check_all();
    check("t_en",        t_en_o,        m_busy);
    check("data_valid",  data_valid_o,  m_q.size() > 0);
    check("data_out",    data_out_o,    (m_q.size() > 0) ? m_q[0] : 16'h0);
    check("count",       count_o,       m_q.size());
    check("full",        full_o,        m_q.size() == DEPTH);
    check("timeout_err", timeout_err_o, m_tmo);
    check("drop_err",    drop_err_o,    m_drop);
  endtask

  task automatic step(input bit st, input bit tv, input logic [15:0] tout, input bit rd);
    @(negedge clk_i);
    start_i = st; t_valid_i = tv; t_out_i = tout; rd_en_i = rd;
    @(posedge clk_i);
    model_edge(st, tv, tout, rd);
    #1;
    check_all();
  endtask

  task automatic capture(input logic [15:0] v, input int wait_cyc, input bit rd_on_cap);
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < wait_cyc; i++) step(0, 0, 16'h0, 0);
    step(0, 1, v, rd_on_cap);
  endtask

  initial begin
    rst_ni = 1'b0; start_i = 0; t_valid_i = 0; t_out_i = '0; rd_en_i = 0;
    model_reset();
    #12;
    check_all();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Capture on the third request cycle.
    capture(16'h1234, 2, 0);
    check("cap1234", data_out_o, 16'h1234);
    step(0, 0, 16'h0, 1);

    // Fill, refused start, drain in order.
    for (int v = 1; v <= 4; v++) capture(16'(v), v % 3, 0);
    step(1, 0, 16'h0, 0);
    check("drop_pulse", drop_err_o, 1'b1);
    step(0, 0, 16'h0, 0);
    for (int v = 1; v <= 4; v++) begin
      check("head_order", data_out_o, 16'(v));
      step(0, 0, 16'h0, 1);
    end
    check("drained", {15'h0, data_valid_o, data_out_o}, 32'h0);

    // Silent generator, then a sample on the last allowed cycle.
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < TIMEOUT; i++) step(0, 0, 16'h0, 0);
    check("tmo_seen", timeout_err_o, 1'b1);
    capture(16'hA5A5, TIMEOUT - 1, 0);
    check("late_cap", timeout_err_o, 1'b0);

    // Simultaneous capture and pop, then wrap-around pairs.
    capture(16'h5555, 0, 0);
    capture(16'hFFFF, 1, 1);
    check("same_edge_cnt", count_o, 2);
    for (int i = 0; i < 10; i++) capture(16'($urandom), $urandom_range(0, 2), 1);

    // Spurious sample in IDLE.
    step(0, 1, 16'hBEEF, 0);

    // Asynchronous reset mid-request.
    step(1, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("async_ten", t_en_o, 1'b0);
    check("async_cnt", count_o, 0);
    check("async_dv",  data_valid_o, 1'b0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    capture(16'h0F0F, 1, 0);

    // Random traffic, including spurious samples and occasional timeouts.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 1), $urandom_range(0, 3) == 0, 16'($urandom), $urandom_range(0, 2) == 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
